// File: rtl/ir_burst_sequencer.sv
// ir_burst_sequencer
//   Multi-channel IR code player. Walks a table of IR code records held in a
//   synchronous ROM and drives CHANNELS LED outputs with gated carrier bursts.
//   Record layout: W0 carrier half-period (0 = end of table), W1 pair count,
//   then that many {on_units, off_units} pairs. Records are packed back to back.
//
// Ports
//   clock_in, reset_in        clock, asynchronous active-high reset
//   start_in                  start request, honoured in IDLE or FAIL only
//   abort_in                  return to IDLE on the next clock, beats start_in
//   loop_forever_in           replay the table until aborted (latched at start)
//   repeat_in                 extra passes after the first (latched at start)
//   chan_mask_in              enabled LED channels (latched at start)
//   mem_addr_out/mem_data_in  ROM address / data (data valid one clock later)
//   ir_out                    carrier AND mask while emitting, else 0
//   busy_out                  high in every state except IDLE and FAIL
//   fail_out                  sticky failure (empty table, n=0, overflow)
//   done_out                  one-clock pulse on entry to IDLE after last pass
//   code_index_out            index of the code being played
//
// Handshake: no valid/ready pairs. start_in is a level request sampled only
// while idle or failed; abort_in is a level that wins over everything.
module ir_burst_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int CTC_WIDTH   = 8,
    parameter int DELAY_WIDTH = 16,
    parameter int ADDR_WIDTH  = 13,
    parameter int UNIT_DIV    = 10,
    parameter int GAP_UNITS   = 250
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic                   loop_forever_in,
    input  logic [7:0]             repeat_in,
    input  logic [CHANNELS-1:0]    chan_mask_in,
    output logic [ADDR_WIDTH-1:0]  mem_addr_out,
    input  logic [DELAY_WIDTH-1:0] mem_data_in,
    output logic [CHANNELS-1:0]    ir_out,
    output logic                   busy_out,
    output logic                   fail_out,
    output logic                   done_out,
    output logic [7:0]             code_index_out
);

    // Durations are multiplied out in DELAY_WIDTH+8 bits so no product truncates.
    localparam int TW = DELAY_WIDTH + 8;
    localparam logic [TW-1:0]         UNIT_CLKS = TW'(UNIT_DIV);
    localparam logic [TW-1:0]         GAP_CLKS  = TW'(GAP_UNITS * UNIT_DIV);
    localparam logic [TW-1:0]         TW_ONE    = TW'(1);
    localparam logic [CTC_WIDTH-1:0]  CTC_ONE   = CTC_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ADDR_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_F_CARR, S_F_CNT, S_F_ON, S_F_OFF,
        S_EMIT_ON, S_EMIT_OFF, S_GAP, S_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;        // fetch: 0 = drive address, 1 = capture
    logic [ADDR_WIDTH:0]    addr_q, addr_d;          // extra MSB flags overflow
    logic [CTC_WIDTH-1:0]   h_q, h_d;
    logic [CTC_WIDTH-1:0]   ctc_q, ctc_d;
    logic                   carrier_q, carrier_d;
    logic [7:0]             pairs_q, pairs_d;
    logic [DELAY_WIDTH-1:0] on_q, on_d;
    logic [DELAY_WIDTH-1:0] off_q, off_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [CHANNELS-1:0]    mask_q, mask_d;
    logic                   loop_q, loop_d;
    logic [7:0]             repeat_q, repeat_d;
    logic [7:0]             passes_q, passes_d;
    logic [7:0]             code_idx_q, code_idx_d;
    logic                   last_pass_q, last_pass_d; // next GAP ends in IDLE
    logic                   fail_q, fail_d;
    logic                   done_q, done_d;

    logic                   is_fetch, word_ready, finish_pair;
    logic [TW-1:0]          data_prod, on_prod, off_prod;

    assign is_fetch   = (state_q == S_F_CARR) || (state_q == S_F_CNT) ||
                        (state_q == S_F_ON)   || (state_q == S_F_OFF);
    assign word_ready = is_fetch && phase_q;
    assign data_prod  = TW'(mem_data_in) * UNIT_CLKS;
    assign on_prod    = TW'(on_q) * UNIT_CLKS;
    assign off_prod   = TW'(off_q) * UNIT_CLKS;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            h_q         <= '0;
            ctc_q       <= '0;
            carrier_q   <= 1'b0;
            pairs_q     <= '0;
            on_q        <= '0;
            off_q       <= '0;
            timer_q     <= '0;
            mask_q      <= '0;
            loop_q      <= 1'b0;
            repeat_q    <= '0;
            passes_q    <= '0;
            code_idx_q  <= '0;
            last_pass_q <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            h_q         <= h_d;
            ctc_q       <= ctc_d;
            carrier_q   <= carrier_d;
            pairs_q     <= pairs_d;
            on_q        <= on_d;
            off_q       <= off_d;
            timer_q     <= timer_d;
            mask_q      <= mask_d;
            loop_q      <= loop_d;
            repeat_q    <= repeat_d;
            passes_q    <= passes_d;
            code_idx_q  <= code_idx_d;
            last_pass_q <= last_pass_d;
            fail_q      <= fail_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        h_d         = h_q;
        ctc_d       = ctc_q;
        carrier_d   = carrier_q;
        pairs_d     = pairs_q;
        on_d        = on_q;
        off_d       = off_q;
        timer_d     = timer_q;
        mask_d      = mask_q;
        loop_d      = loop_q;
        repeat_d    = repeat_q;
        passes_d    = passes_q;
        code_idx_d  = code_idx_q;
        last_pass_d = last_pass_q;
        fail_d      = fail_q;
        done_d      = 1'b0;
        finish_pair = 1'b0;

        // Shared two-clock fetch: the address phase refuses to run past the
        // top of the ROM, the capture phase advances the address.
        if (is_fetch) begin
            if (!phase_q) begin
                if (addr_q[ADDR_WIDTH]) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    phase_d = 1'b1;
                end
            end else begin
                phase_d = 1'b0;
                addr_d  = addr_q + ADDR_ONE;
            end
        end

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start_in && !abort_in) begin
                    mask_d      = chan_mask_in;
                    loop_d      = loop_forever_in;
                    repeat_d    = repeat_in;
                    passes_d    = '0;
                    fail_d      = 1'b0;
                    addr_d      = '0;
                    code_idx_d  = '0;
                    last_pass_d = 1'b0;
                    phase_d     = 1'b0;
                    state_d     = S_F_CARR;
                end
            end
            S_F_CARR: begin
                if (word_ready) begin
                    if (mem_data_in[CTC_WIDTH-1:0] == '0) begin
                        if (code_idx_q == 8'd0) begin
                            state_d = S_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                            timer_d = GAP_CLKS - TW_ONE;
                            if (loop_q || (passes_q < repeat_q)) begin
                                passes_d   = passes_q + 8'd1;
                                addr_d     = '0;
                                code_idx_d = '0;
                            end else begin
                                last_pass_d = 1'b1;
                            end
                        end
                    end else begin
                        h_d     = mem_data_in[CTC_WIDTH-1:0];
                        state_d = S_F_CNT;
                    end
                end
            end
            S_F_CNT: begin
                if (word_ready) begin
                    if (mem_data_in[7:0] == 8'd0) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        pairs_d = mem_data_in[7:0];
                        state_d = S_F_ON;
                    end
                end
            end
            S_F_ON: begin
                if (word_ready) begin
                    on_d    = mem_data_in;
                    state_d = S_F_OFF;
                end
            end
            S_F_OFF: begin
                if (word_ready) begin
                    off_d = mem_data_in;
                    if (on_q != '0) begin
                        state_d   = S_EMIT_ON;
                        timer_d   = on_prod - TW_ONE;
                        ctc_d     = h_q - CTC_ONE;
                        carrier_d = 1'b1;
                    end else if (mem_data_in != '0) begin
                        state_d = S_EMIT_OFF;
                        timer_d = data_prod - TW_ONE;
                    end else begin
                        finish_pair = 1'b1;
                    end
                end
            end
            S_EMIT_ON: begin
                // Carrier flips after h clocks in each phase, high phase first.
                if (ctc_q == '0) begin
                    carrier_d = ~carrier_q;
                    ctc_d     = h_q - CTC_ONE;
                end else begin
                    ctc_d = ctc_q - CTC_ONE;
                end
                if (timer_q == '0) begin
                    if (off_q != '0) begin
                        state_d = S_EMIT_OFF;
                        timer_d = off_prod - TW_ONE;
                    end else begin
                        finish_pair = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW_ONE;
                end
            end
            S_EMIT_OFF: begin
                if (timer_q == '0) finish_pair = 1'b1;
                else               timer_d = timer_q - TW_ONE;
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    if (last_pass_q) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        last_pass_d = 1'b0;
                    end else begin
                        state_d = S_F_CARR;
                    end
                end else begin
                    timer_d = timer_q - TW_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish_pair) begin
            pairs_d = pairs_q - 8'd1;
            if (pairs_q != 8'd1) begin
                state_d = S_F_ON;
            end else begin
                code_idx_d = code_idx_q + 8'd1;
                timer_d    = GAP_CLKS - TW_ONE;
                state_d    = S_GAP;
            end
        end

        if (abort_in) begin
            state_d     = S_IDLE;
            phase_d     = 1'b0;
            done_d      = 1'b0;
            last_pass_d = 1'b0;
        end
    end

    assign mem_addr_out   = addr_q[ADDR_WIDTH-1:0];
    assign ir_out         = (state_q == S_EMIT_ON) ? ({CHANNELS{carrier_q}} & mask_q) : '0;
    assign busy_out       = (state_q != S_IDLE) && (state_q != S_FAIL);
    assign fail_out       = fail_q;
    assign done_out       = done_q;
    assign code_index_out = code_idx_q;

endmodule

// File: tb/tb_ir_burst_sequencer.sv
module tb_ir_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, lf;
    logic [7:0]  rep;
    logic [3:0]  mask;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic [3:0]  ir;
    logic        busy, fail, done;
    logic [7:0]  code_idx;
    logic [15:0] rom [16];

    int total = 0;
    int bad   = 0;

    ir_burst_sequencer #(
        .CHANNELS(4), .CTC_WIDTH(8), .DELAY_WIDTH(16), .ADDR_WIDTH(4),
        .UNIT_DIV(10), .GAP_UNITS(5)
    ) dut (
        .clock_in(clk), .reset_in(rst), .start_in(start), .abort_in(abort),
        .loop_forever_in(lf), .repeat_in(rep), .chan_mask_in(mask),
        .mem_addr_out(mem_addr), .mem_data_in(mem_data), .ir_out(ir),
        .busy_out(busy), .fail_out(fail), .done_out(done), .code_index_out(code_idx)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: data valid one clock after the address.
    always @(posedge clk) mem_data <= rom[mem_addr];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 16; i++) rom[i] = 16'd0;
    endtask

    task automatic load_code(input int h, input int n, input int on0, input int off0,
                             input int on1, input int off1);
        rom_clear();
        rom[0] = 16'(h);  rom[1] = 16'(n);
        rom[2] = 16'(on0); rom[3] = 16'(off0);
        if (n == 2) begin
            rom[4] = 16'(on1); rom[5] = 16'(off1);
        end
    endtask

    // Issue a one-clock start and watch the run until busy drops.
    // Cycle 1 is the first clock after the start edge.
    task automatic play(input logic lf_i, input logic [7:0] rep_i, input logic [3:0] msk,
                        input int limit, output int busy_len, output int first_hi,
                        output int high_cnt, output int bad_cnt, output int bursts,
                        output int last_run, output int done_cnt, output int max_ci,
                        output logic fail_c1, output logic fail_end);
        int  zrun;
        logic prev_nz;
        logic timed_out;
        lf = lf_i; rep = rep_i; mask = msk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_len = 0; first_hi = -1; high_cnt = 0; bad_cnt = 0; bursts = 0;
        last_run = 0; done_cnt = 0; max_ci = 0; zrun = 0; prev_nz = 1'b0;
        timed_out = 1'b1; fail_c1 = fail;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done) done_cnt++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_len = cyc;
            if (int'(code_idx) > max_ci) max_ci = int'(code_idx);
            if (ir != 4'd0) begin
                if (first_hi < 0) first_hi = cyc;
                if (!prev_nz && zrun >= 8) begin
                    bursts++;
                    last_run = zrun;
                end
                zrun = 0;
                prev_nz = 1'b1;
            end else begin
                zrun++;
                prev_nz = 1'b0;
            end
            if (ir == msk) high_cnt++;
            if (ir != 4'd0 && ir != msk) bad_cnt++;
        end
        chk("play_timeout", int'(timed_out), 0);
        fail_end = fail;
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    typedef struct {
        int h; int n; int on0; int off0; int on1; int off1;
        logic [3:0] msk;
        int e_first; int e_high; int e_busy; int e_bursts; int e_run;
    } vec_t;

    vec_t vt [6];

    initial begin
        int bl, fh, hc, bc, bu, lr, dc, mc;
        logic f1, fe;
        int n_done;
        logic timed_out;

        vt[0] = '{3, 1, 2, 1, 0, 0, 4'b0101,  9, 11, 140, 1,  8};
        vt[1] = '{1, 1, 1, 2, 0, 0, 4'b1111,  9,  5, 140, 1,  8};
        vt[2] = '{5, 1, 3, 0, 0, 0, 4'b1010,  9, 15, 140, 1,  8};
        vt[3] = '{4, 1, 0, 2, 0, 0, 4'b1111, -1,  0, 130, 0,  0};
        vt[4] = '{7, 1, 1, 1, 0, 0, 4'b0011,  9,  7, 130, 1,  8};
        vt[5] = '{2, 2, 1, 3, 1, 0, 4'b0110,  9, 12, 164, 2, 34};

        rst = 1'b1; start = 1'b0; abort = 1'b0; lf = 1'b0; rep = 8'd0; mask = 4'd0;
        rom_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ir", int'(ir), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fail", int'(fail), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_code_idx", int'(code_idx), 0);

        // Table-driven single-pass bursts.
        for (int k = 0; k < 6; k++) begin
            load_code(vt[k].h, vt[k].n, vt[k].on0, vt[k].off0, vt[k].on1, vt[k].off1);
            play(1'b0, 8'd0, vt[k].msk, 1000, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
            chk($sformatf("v%0d_first_high", k), fh, vt[k].e_first);
            chk($sformatf("v%0d_high_clocks", k), hc, vt[k].e_high);
            chk($sformatf("v%0d_masked_bits", k), bc, 0);
            chk($sformatf("v%0d_busy_len", k), bl, vt[k].e_busy);
            chk($sformatf("v%0d_bursts", k), bu, vt[k].e_bursts);
            chk($sformatf("v%0d_gap_before_last", k), lr, vt[k].e_run);
            chk($sformatf("v%0d_done_pulses", k), dc, 1);
            chk($sformatf("v%0d_fail", k), int'(fe), 0);
            chk($sformatf("v%0d_code_idx", k), mc, 1);
        end

        // Two extra passes: three bursts, one done at the very end.
        load_code(3, 1, 2, 1, 0, 0);
        play(1'b0, 8'd2, 4'b0101, 1000, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
        chk("rep_busy_len", bl, 420);
        chk("rep_bursts", bu, 3);
        chk("rep_gap_before_last", lr, 120);
        chk("rep_high_clocks", hc, 33);
        chk("rep_done_pulses", dc, 1);

        // Record with zero pairs fails; next start clears fail and replays.
        load_code(3, 0, 0, 0, 0, 0);
        play(1'b0, 8'd0, 4'b1111, 500, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
        chk("n0_busy_len", bl, 4);
        chk("n0_fail", int'(fe), 1);
        chk("n0_done_pulses", dc, 0);
        load_code(3, 1, 2, 1, 0, 0);
        play(1'b0, 8'd0, 4'b0101, 1000, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
        chk("restart_fail_cleared", int'(f1), 0);
        chk("restart_bursts", bu, 1);
        chk("restart_busy_len", bl, 140);
        chk("restart_done_pulses", dc, 1);

        // Empty table.
        rom_clear();
        play(1'b0, 8'd0, 4'b1111, 500, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
        chk("empty_busy_len", bl, 2);
        chk("empty_fail", int'(fe), 1);
        chk("empty_done_pulses", dc, 0);

        // Four silent records fill the ROM with no terminator: overflow.
        rom_clear();
        for (int r = 0; r < 4; r++) begin
            rom[4*r]   = 16'd1;
            rom[4*r+1] = 16'd1;
        end
        play(1'b0, 8'd0, 4'b1111, 1000, bl, fh, hc, bc, bu, lr, dc, mc, f1, fe);
        chk("ovf_busy_len", bl, 233);
        chk("ovf_fail", int'(fe), 1);
        chk("ovf_bursts", bu, 0);
        chk("ovf_done_pulses", dc, 0);

        // Loop forever with start held high; abort in the third burst.
        load_code(3, 1, 2, 1, 0, 0);
        lf = 1'b1; rep = 8'd0; mask = 4'b1111; start = 1'b1;
        @(negedge clk);
        n_done = 0; bu = 0; lr = 0; timed_out = 1'b1;
        begin
            int zr;
            logic pn;
            zr = 0; pn = 1'b0;
            for (int cyc = 1; cyc <= 2000; cyc++) begin
                @(negedge clk);
                if (done) n_done++;
                if (ir != 4'd0) begin
                    if (!pn && zr >= 8) bu++;
                    zr = 0; pn = 1'b1;
                end else begin
                    zr++; pn = 1'b0;
                end
                if (bu == 3) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        chk("loop_timeout", int'(timed_out), 0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_ir", int'(ir), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("loop_done_pulses", n_done, 0);
        abort = 1'b0; start = 1'b0; lf = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);

        // Asynchronous reset mid-burst.
        load_code(3, 1, 2, 1, 0, 0);
        mask = 4'b1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (ir != 4'd0) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk("arst_burst_seen", int'(timed_out), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ir", int'(ir), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'(mem_addr), 0);
        chk("arst_code_idx", int'(code_idx), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_idle_busy", int'(busy), 0);
        chk("arst_idle_ir", int'(ir), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
